log_unit_arbiter: RTL and testbench

- Shares one iterative log-fraction unit between NUM_CH requesters, typically per-channel envelope paths feeding log compression.
- Grants requesters round-robin, issues one operand to the unit and waits for the result. The result is returned only to the requester that issued the operand.
- A watchdog flushes a hung unit and returns an error response, so that no channel can stall the log stage.

---
 rtl/log_unit_arbiter.sv | 150 +++++++++++++++
 tb/tb_log_unit_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/log_unit_arbiter.sv
// Round-robin arbiter sharing one iterative log-fraction unit between NUM_CH requesters,
// with a WAIT-state watchdog that flushes a hung unit and returns an error response.
module log_unit_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int NORM_WIDTH = 17,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH*NORM_WIDTH-1:0] req_data,
  output logic [NUM_CH-1:0]            rsp_valid,
  input  logic [NUM_CH-1:0]            rsp_ready,
  output logic [NORM_WIDTH-1:0]        rsp_data,
  output logic                         rsp_err,
  output logic                         calc_in_valid,
  input  logic                         calc_in_ready,
  output logic [NORM_WIDTH-1:0]        calc_data,
  input  logic                         calc_out_valid,
  output logic                         calc_out_ready,
  input  logic [NORM_WIDTH-1:0]        calc_result,
  output logic                         calc_flush,
  output logic                         busy,
  output logic                         err_sticky
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         last_grant_q, last_grant_d;
  logic [CH_W-1:0]         grant_q, grant_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [NORM_WIDTH-1:0]   operand_q, operand_d;
  logic [NORM_WIDTH-1:0]   result_q, result_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    err_sticky_q, err_sticky_d;
  logic                    calc_flush_q, calc_flush_d;

  logic                    found;
  logic [CH_W-1:0]         sel;
  logic [CH_W-1:0]         cand;

  // First requester at or after last_grant+1, wrapping; earlier hits take priority.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((int'(last_grant_q) + 1 + k) % NUM_CH);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    timer_d      = timer_q;
    operand_d    = operand_q;
    result_d     = result_q;
    rsp_err_d    = rsp_err_q;
    err_sticky_d = err_sticky_q;
    calc_flush_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d   = sel;
          operand_d = req_data[sel*NORM_WIDTH +: NORM_WIDTH];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (calc_in_ready) begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result arriving on the timeout cycle wins over the flush.
        if (calc_out_valid) begin
          result_d  = calc_result;
          rsp_err_d = 1'b0;
          state_d   = S_RESP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          calc_flush_d = 1'b1;
          err_sticky_d = 1'b1;
          result_d     = '0;
          rsp_err_d    = 1'b1;
          state_d      = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= CH_W'(NUM_CH - 1);
      grant_q      <= '0;
      timer_q      <= '0;
      operand_q    <= '0;
      result_q     <= '0;
      rsp_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      calc_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      timer_q      <= timer_d;
      operand_q    <= operand_d;
      result_q     <= result_d;
      rsp_err_q    <= rsp_err_d;
      err_sticky_q <= err_sticky_d;
      calc_flush_q <= calc_flush_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE && found) ? (CH_ONE << sel) : '0;
  assign rsp_valid      = (state_q == S_RESP) ? (CH_ONE << grant_q) : '0;
  assign rsp_data       = result_q;
  assign rsp_err        = rsp_err_q;
  assign calc_in_valid  = (state_q == S_ISSUE);
  assign calc_out_ready = (state_q == S_WAIT);
  assign calc_data      = operand_q;
  assign calc_flush     = calc_flush_q;
  assign busy           = (state_q != S_IDLE);
  assign err_sticky     = err_sticky_q;

endmodule

// File: tb/tb_log_unit_arbiter.sv
// Directed bench for log_unit_arbiter: the initial block plays requesters and the log unit.
module tb_log_unit_arbiter;

  localparam int NCH = 4;
  localparam int W   = 17;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NCH*W-1:0] req_data;
  logic [W-1:0]     rsp_data, calc_data, calc_result;
  logic             rsp_err, calc_in_valid, calc_in_ready, calc_out_valid, calc_out_ready;
  logic             calc_flush, busy, err_sticky;

  int compared   = 0;
  int mismatched = 0;
  int n;

  log_unit_arbiter #(.NUM_CH(NCH), .NORM_WIDTH(W), .TIMEOUT(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .calc_in_valid(calc_in_valid), .calc_in_ready(calc_in_ready), .calc_data(calc_data),
    .calc_out_valid(calc_out_valid), .calc_out_ready(calc_out_ready), .calc_result(calc_result),
    .calc_flush(calc_flush), .busy(busy), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation with calc_in_ready high and a 1-cycle result pulse lat cycles into WAIT.
  task automatic run_op(input string tag, input logic [NCH-1:0] grant, input logic [W-1:0] op,
                        input logic [W-1:0] res, input int lat, input logic clear_req);
    #1;
    check({tag, " req_ready"}, 32'(req_ready), 32'(grant));
    step();
    if (clear_req) req_valid = req_valid & ~grant;
    check({tag, " issue valid"}, 32'(calc_in_valid), 32'd1);
    check({tag, " issue data"}, 32'(calc_data), 32'(op));
    step();
    check({tag, " wait ready"}, {30'd0, calc_out_ready, calc_in_valid}, 32'b10);
    repeat (lat - 1) step();
    check({tag, " wait data"}, 32'(calc_data), 32'(op));
    calc_out_valid = 1'b1;
    calc_result    = res;
    step();
    calc_out_valid = 1'b0;
    calc_result    = 17'h15A5A;
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(grant));
    check({tag, " rsp_data"}, 32'(rsp_data), 32'(res));
    check({tag, " rsp_err/flush"}, {30'd0, rsp_err, calc_flush}, 32'd0);
    check({tag, " no grant in resp"}, 32'(req_ready), 32'd0);
    rsp_ready = grant;
    step();
    rsp_ready = '0;
    check({tag, " rsp done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = '0;
    req_data       = '0;
    rsp_ready      = '0;
    calc_in_ready  = 1'b1;
    calc_out_valid = 1'b0;
    calc_result    = '0;
    repeat (3) step();
    reset = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset outputs", {15'd0, calc_data, rsp_valid, calc_in_valid, calc_out_ready,
                            calc_flush, err_sticky}, 32'd0);

    req_data[0*W +: W] = 17'h01111;
    req_data[1*W +: W] = 17'h02222;
    req_data[2*W +: W] = 17'h10000;
    req_data[3*W +: W] = 17'h03333;

    // Single channel: ch2 alone, result 0 after 20 cycles.
    req_valid = 4'b0100;
    run_op("single", 4'b0100, 17'h10000, 17'h00000, 20, 1'b1);
    check("single idle", 32'(busy), 32'd0);

    // Round-robin from reset with all channels requesting.
    reset = 1'b1;
    step();
    reset     = 1'b0;
    req_valid = 4'b1111;
    run_op("rr0", 4'b0001, 17'h01111, 17'h00B5D, 1, 1'b0);
    run_op("rr1", 4'b0010, 17'h02222, 17'h12345, 3, 1'b0);
    run_op("rr2", 4'b0100, 17'h10000, 17'h1FFFF, 5, 1'b0);
    run_op("rr3", 4'b1000, 17'h03333, 17'h0F0F0, 2, 1'b0);
    run_op("rr4", 4'b0001, 17'h01111, 17'h07777, 4, 1'b0);
    req_valid = '0;

    // Back-pressure: ch1 issue stalled 5 cycles, response stalled 7 cycles.
    calc_in_ready = 1'b0;
    req_valid     = 4'b0010;
    #1;
    check("bp req_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      check("bp issue hold", {14'd0, calc_data, calc_in_valid}, {14'd0, 17'h02222, 1'b1});
      check("bp no wait", 32'(calc_out_ready), 32'd0);
      step();
    end
    calc_in_ready = 1'b1;
    step();
    check("bp wait entry", 32'(calc_out_ready), 32'd1);
    repeat (2) step();
    calc_out_valid = 1'b1;
    calc_result    = 17'h1ABCD;
    step();
    calc_out_valid = 1'b0;
    calc_result    = '0;
    rsp_ready      = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      check("bp rsp hold", {11'd0, rsp_data, rsp_valid}, {11'd0, 17'h1ABCD, 4'b0010});
      step();
    end
    rsp_ready = 4'b0010;
    step();
    rsp_ready = '0;
    check("bp rsp done", 32'(rsp_valid), 32'd0);

    // Timeout on ch2: unit never answers.
    req_valid = 4'b0100;
    #1;
    check("to req_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    step();
    n = 0;
    while (calc_flush !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("to flush delay", 32'(n), 32'd32);
    check("to rsp_valid", 32'(rsp_valid), 32'b0100);
    check("to rsp_err", 32'(rsp_err), 32'd1);
    check("to rsp_data", 32'(rsp_data), 32'd0);
    check("to err_sticky", 32'(err_sticky), 32'd1);
    step();
    check("to flush pulse", {30'd0, calc_flush, rsp_err}, 32'b01);
    rsp_ready = 4'b0100;
    step();
    rsp_ready = '0;
    check("to idle", 32'(busy), 32'd0);

    // Normal operation after a timeout; sticky error persists.
    req_valid = 4'b1000;
    run_op("post_to", 4'b1000, 17'h03333, 17'h05555, 3, 1'b1);
    check("post_to sticky", 32'(err_sticky), 32'd1);

    // Result arrives on the same cycle the timer expires: result wins.
    req_valid = 4'b0001;
    run_op("race", 4'b0001, 17'h01111, 17'h1F00F, 32, 1'b1);

    // Reset during WAIT: back to IDLE, no response ever.
    req_valid = 4'b0010;
    #1;
    check("rst req_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    step();
    repeat (5) step();
    check("rst in wait", 32'(calc_out_ready), 32'd1);
    reset = 1'b1;
    step();
    check("rst busy", 32'(busy), 32'd0);
    check("rst state outs", {28'd0, calc_out_ready, calc_flush, err_sticky, rsp_err}, 32'd0);
    reset          = 1'b0;
    calc_out_valid = 1'b1;
    calc_result    = 17'h12345;
    step();
    calc_out_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rst no rsp", {27'd0, busy, rsp_valid}, 32'd0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
